sprattr_linescan: RTL

Parametrised sprite attribute table with an integrated per-scanline sprite evaluator. The CPU side reads and writes attributes through a two-word-per-sprite window with byte enables. The video side no longer indexes sprites directly: it pulses a start with a line number, and the block walks all sprites in order, streaming up to MAX_PER_LINE hits through a valid/ready interface. It sits between the CPU bus decode and the sprite line renderer.

---
 rtl/sprattr_linescan_if.sv | 49 ++++
 rtl/sprattr_linescan.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/sprattr_linescan_if.sv
// Bus bundle between the CPU decode / line renderer side and sprattr_linescan.
// SEL_W must match the SEL_W of the attached sprattr_linescan instance.
//
// Handshake: a record on out_* transfers on every rising clk edge where
// out_valid and out_ready are both 1. While out_valid=1 and out_ready=0 the
// record is held unchanged. out_valid never depends on out_ready in the same
// cycle. scan_start overrides the handshake and discards any pending record.
interface sprattr_linescan_if #(
  parameter int SEL_W = 6
);
  logic [SEL_W:0]   sprattr_addr;
  logic [31:0]      sprattr_wrdata;
  logic [3:0]       sprattr_bytesel;
  logic             sprattr_wren;
  logic [31:0]      sprattr_rddata;
  logic             scan_start;
  logic [7:0]       scan_line;
  logic             scan_busy;
  logic             scan_done;
  logic             scan_overflow;
  logic [SEL_W:0]   scan_count;
  logic             out_valid;
  logic             out_ready;
  logic [SEL_W-1:0] out_sprnum;
  logic [8:0]       out_x;
  logic [9:0]       out_idx;
  logic [3:0]       out_row;
  logic             out_h16;
  logic             out_hflip;
  logic             out_priority;
  logic [1:0]       out_palette;
  logic [1:0]       dbg_state;

  modport slave (
    input  sprattr_addr, sprattr_wrdata, sprattr_bytesel, sprattr_wren,
           scan_start, scan_line, out_ready,
    output sprattr_rddata, scan_busy, scan_done, scan_overflow, scan_count,
           out_valid, out_sprnum, out_x, out_idx, out_row, out_h16,
           out_hflip, out_priority, out_palette, dbg_state
  );

  modport master (
    output sprattr_addr, sprattr_wrdata, sprattr_bytesel, sprattr_wren,
           scan_start, scan_line, out_ready,
    input  sprattr_rddata, scan_busy, scan_done, scan_overflow, scan_count,
           out_valid, out_sprnum, out_x, out_idx, out_row, out_h16,
           out_hflip, out_priority, out_palette, dbg_state
  );
endinterface

// File: rtl/sprattr_linescan.sv
// Sprite attribute table with a per-scanline evaluator. The CPU reads and
// writes two words per sprite; the video side starts a scan for one line and
// receives the visible sprites, in sprite order, through a one-entry output
// register. dbg_state exposes the scan FSM state (0 idle, 1 scan, 2 drain).
module sprattr_linescan #(
  parameter int NUM_SPR      = 64,
  parameter int SEL_W        = 6,
  parameter int MAX_PER_LINE = 16
) (
  input logic                clk,
  input logic                reset,
  sprattr_linescan_if.slave  bus
);
  localparam logic [31:0]    POS_MASK = 32'h00FF_01FF;
  localparam logic [31:0]    ATT_MASK = 32'h0000_FFFF;
  localparam logic [SEL_W:0] MAX_CNT  = (SEL_W+1)'(MAX_PER_LINE);
  localparam logic [SEL_W-1:0] LAST_SPR = SEL_W'(NUM_SPR - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DRAIN = 2'd2} state_t;

  // Table storage; not reset, undefined until written.
  logic [31:0] pos_mem [NUM_SPR];
  logic [31:0] att_mem [NUM_SPR];

  logic [SEL_W-1:0] cpu_spr;
  logic [31:0]      word_mask, wr_mask, cpu_old, cpu_new;
  logic [31:0]      rddata_d, rddata_q;

  state_t           state_d, state_q;
  logic [7:0]       line_d, line_q;
  logic [SEL_W-1:0] idx_d, idx_q;
  logic [SEL_W:0]   count_d, count_q;
  logic             ovf_d, ovf_q;
  logic             valid_d, valid_q;
  logic [SEL_W-1:0] sprnum_d, sprnum_q;
  logic [8:0]       x_d, x_q;
  logic [9:0]       tidx_d, tidx_q;
  logic [3:0]       row_d, row_q;
  logic             h16_d, h16_q, hflip_d, hflip_q, pri_d, pri_q;
  logic [1:0]       pal_d, pal_q;

  logic [8:0]       scan_x;
  logic [7:0]       scan_y, diff;
  logic [15:0]      scan_att;
  logic             hit, out_free;
  logic [3:0]       hit_row;

  // CPU port: byte-masked merge of the addressed word; reads return the old value.
  always_comb begin
    cpu_spr   = bus.sprattr_addr[SEL_W:1];
    word_mask = bus.sprattr_addr[0] ? ATT_MASK : POS_MASK;
    wr_mask   = {{8{bus.sprattr_bytesel[3]}}, {8{bus.sprattr_bytesel[2]}},
                 {8{bus.sprattr_bytesel[1]}}, {8{bus.sprattr_bytesel[0]}}} & word_mask;
    cpu_old   = bus.sprattr_addr[0] ? att_mem[cpu_spr] : pos_mem[cpu_spr];
    cpu_new   = ((cpu_old & ~wr_mask) | (bus.sprattr_wrdata & wr_mask)) & word_mask;
    rddata_d  = cpu_old & word_mask;
  end

  // Table write port.
  always_ff @(posedge clk) begin
    if (bus.sprattr_wren) begin
      if (bus.sprattr_addr[0]) att_mem[cpu_spr] <= cpu_new;
      else                     pos_mem[cpu_spr] <= cpu_new;
    end
  end

  // Hit test for the sprite under the scan index; diff wraps so Y near 255 reaches the top lines.
  always_comb begin
    scan_x   = pos_mem[idx_q][8:0];
    scan_y   = pos_mem[idx_q][23:16];
    scan_att = att_mem[idx_q][15:0];
    diff     = line_q - scan_y;
    hit      = scan_att[10] ? (diff < 8'd16) : (diff < 8'd8);
    if (!scan_att[12])     hit_row = diff[3:0];
    else if (scan_att[10]) hit_row = 4'd15 - diff[3:0];
    else                   hit_row = {1'b0, 3'd7 - diff[2:0]};
  end

  assign out_free = !valid_q || bus.out_ready;

  // Scan FSM next state and output register load.
  always_comb begin
    state_d  = state_q;
    line_d   = line_q;
    idx_d    = idx_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    valid_d  = valid_q;
    sprnum_d = sprnum_q;
    x_d      = x_q;
    tidx_d   = tidx_q;
    row_d    = row_q;
    h16_d    = h16_q;
    hflip_d  = hflip_q;
    pri_d    = pri_q;
    pal_d    = pal_q;
    if (valid_q && bus.out_ready) valid_d = 1'b0;
    if (bus.scan_start) begin
      line_d  = bus.scan_line;
      state_d = SCAN;
      idx_d   = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        SCAN: begin
          if (hit && count_q == MAX_CNT) begin
            ovf_d   = 1'b1;
            state_d = DRAIN;
          end else if (!hit || out_free) begin
            if (hit) begin
              valid_d  = 1'b1;
              count_d  = count_q + 1'b1;
              sprnum_d = idx_q;
              x_d      = scan_x;
              tidx_d   = scan_att[9:0];
              row_d    = hit_row;
              h16_d    = scan_att[10];
              hflip_d  = scan_att[11];
              pal_d    = scan_att[14:13];
              pri_d    = scan_att[15];
            end
            if (idx_q == LAST_SPR) state_d = DRAIN;
            else                   idx_d   = idx_q + 1'b1;
          end
        end
        DRAIN:   if (out_free) state_d = IDLE;
        default: ;
      endcase
    end
  end

  // State and output registers; the table itself survives reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      line_q   <= '0;
      idx_q    <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
      sprnum_q <= '0;
      x_q      <= '0;
      tidx_q   <= '0;
      row_q    <= '0;
      h16_q    <= 1'b0;
      hflip_q  <= 1'b0;
      pri_q    <= 1'b0;
      pal_q    <= '0;
      rddata_q <= '0;
    end else begin
      state_q  <= state_d;
      line_q   <= line_d;
      idx_q    <= idx_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
      sprnum_q <= sprnum_d;
      x_q      <= x_d;
      tidx_q   <= tidx_d;
      row_q    <= row_d;
      h16_q    <= h16_d;
      hflip_q  <= hflip_d;
      pri_q    <= pri_d;
      pal_q    <= pal_d;
      rddata_q <= rddata_d;
    end
  end

  // Done fires in the drain cycle that releases the last record, unless a restart arrives.
  assign bus.scan_done      = (state_q == DRAIN) && out_free && !bus.scan_start;
  assign bus.scan_busy      = (state_q != IDLE);
  assign bus.scan_overflow  = ovf_q;
  assign bus.scan_count     = count_q;
  assign bus.sprattr_rddata = rddata_q;
  assign bus.out_valid      = valid_q;
  assign bus.out_sprnum     = sprnum_q;
  assign bus.out_x          = x_q;
  assign bus.out_idx        = tidx_q;
  assign bus.out_row        = row_q;
  assign bus.out_h16        = h16_q;
  assign bus.out_hflip      = hflip_q;
  assign bus.out_priority   = pri_q;
  assign bus.out_palette    = pal_q;
  assign bus.dbg_state      = state_q;
endmodule
